// File: rtl/mux_rr_sel.sv
// Round-robin select stage for a 2:1 mux with bounded bursts and a 1-deep valid/ready output register.
// Optional per-channel accepted-beat counters (cnt0/cnt1) when SEL_STATS_EN is defined.
module mux_rr_sel #(
    parameter int WIDTH = 1,
    parameter int HOLD  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic             req0,
    input  logic             req1,
    input  logic             out_rdy,
    output logic             gnt0,
    output logic             gnt1,
    output logic             s,
    output logic [WIDTH-1:0] y,
    output logic             y_vld
`ifdef SEL_STATS_EN
    ,
    output logic [7:0]       cnt0,
    output logic [7:0]       cnt1
`endif
);

    localparam int CW = (HOLD < 1) ? 1 : $clog2(HOLD + 1);
    localparam logic [CW-1:0] HOLD_C = CW'(HOLD);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          last;
    logic          w;
    logic          accept;
    logic          keep_owner;
    state_t        win_state;
    logic [CW-1:0] cnt_next;

    // Owner keeps the channel while it still requests and has burst budget left
    // (or nobody else is waiting); otherwise the other requester takes over.
    always_comb begin
        w = last;
        case (state)
            OWN0: begin
                if (req0 && ((cnt < HOLD_C) || !req1))
                    w = 1'b0;
                else if (req1)
                    w = 1'b1;
            end
            OWN1: begin
                if (req1 && ((cnt < HOLD_C) || !req0))
                    w = 1'b1;
                else if (req0)
                    w = 1'b0;
            end
            default: begin
                if (req0 && req1)
                    w = ~last;
                else if (req0)
                    w = 1'b0;
                else if (req1)
                    w = 1'b1;
            end
        endcase
    end

    // Grants are suppressed while rst is high so they clear asynchronously too.
    assign accept     = !rst && (req0 || req1) && (!y_vld || out_rdy);
    assign gnt0       = accept && !w;
    assign gnt1       = accept && w;
    assign s          = w;
    assign win_state  = w ? OWN1 : OWN0;
    assign keep_owner = (state == win_state);
    assign cnt_next   = !keep_owner ? CW'(1) :
                        (cnt == HOLD_C) ? HOLD_C : cnt + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            last  <= 1'b1;
            y     <= '0;
            y_vld <= 1'b0;
        end else begin
            if (accept) begin
                y     <= w ? d1 : d0;
                y_vld <= 1'b1;
                last  <= w;
                state <= win_state;
                cnt   <= cnt_next;
            end else begin
                if (out_rdy)
                    y_vld <= 1'b0;
                if (!req0 && !req1) begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            end
        end
    end

`ifdef SEL_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt0 <= 8'd0;
            cnt1 <= 8'd0;
        end else begin
            if (gnt0 && (cnt0 != 8'hFF))
                cnt0 <= cnt0 + 8'd1;
            if (gnt1 && (cnt1 != 8'hFF))
                cnt1 <= cnt1 + 8'd1;
        end
    end
`endif

endmodule
